// File: rtl/iodiv_pkg.sv
// Shared constants and helpers for the divided-clock / SERDES strobe generator.
package iodiv_pkg;

  localparam int unsigned MAX_DIVIDE_LIMIT = 16;
  localparam int unsigned MAX_CH_LIMIT     = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned iodiv_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Width wide enough for any legal divide ratio or phase.
  localparam int unsigned LIM_W = iodiv_clog2(MAX_DIVIDE_LIMIT + 1);

  // A divide/phase pair is legal when 1 <= divide <= max_divide and phase < divide.
  function automatic logic cfg_legal(input logic [LIM_W-1:0] divide,
                                     input logic [LIM_W-1:0] phase,
                                     input int unsigned      max_divide);
    return (divide != '0) && (32'(divide) <= max_divide) && (phase < divide);
  endfunction

endpackage

// File: rtl/iodiv_strobe_gen_if.sv
// Configuration valid/ready port of the divided-clock / strobe generator.
interface iodiv_strobe_gen_if
  import iodiv_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = iodiv_clog2(8 + 1)
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [CNT_W-1:0]          cfg_divide;
  logic [NUM_CH*CNT_W-1:0]   cfg_phase;
  logic                      cfg_err;

  modport master (output cfg_valid, output cfg_divide, output cfg_phase,
                  input  cfg_ready, input  cfg_err);
  modport slave  (input  cfg_valid, input  cfg_divide, input  cfg_phase,
                  output cfg_ready, output cfg_err);
endinterface

// File: rtl/iodiv_phase_ch.sv
// One output channel: local count = (cnt + phase) mod divide, registered
// divided clock (high for the first ceil(divide/2) counts) and end-of-frame strobe.
module iodiv_phase_ch
  import iodiv_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] divide,
  input  logic [CNT_W-1:0] phase,
  output logic             div_clk,
  output logic             strobe
);
  logic [CNT_W:0] sum, lc, div_x, half;
  logic           div_clk_d, div_clk_q, strobe_d, strobe_q;

  // Local count and next output values from the current frame position.
  always_comb begin
    sum       = {1'b0, cnt} + {1'b0, phase};
    div_x     = {1'b0, divide};
    lc        = (sum >= div_x) ? (sum - div_x) : sum;
    half      = (div_x + (CNT_W+1)'(1)) >> 1;
    div_clk_d = (lc < half);
    strobe_d  = (lc == (div_x - (CNT_W+1)'(1)));
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_clk_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      div_clk_q <= div_clk_d;
      strobe_q  <= strobe_d;
    end
  end

  assign div_clk = div_clk_q;
  assign strobe  = strobe_q;
endmodule

// File: rtl/iodiv_strobe_gen.sv
// Multi-channel divided-clock / SERDES strobe generator with run-time
// divide/phase configuration applied only at frame boundaries or on sync.
// Optional feature macro: IODIV_FRAME_CNT_EN adds a 16-bit frame counter output.
module iodiv_strobe_gen
  import iodiv_pkg::*;
#(
  parameter  int unsigned MAX_DIVIDE   = 8,
  parameter  int unsigned NUM_CH       = 2,
  parameter  int unsigned RESET_DIVIDE = 4,
  localparam int unsigned CNT_W        = iodiv_clog2(MAX_DIVIDE + 1)
) (
  input  logic               clk,
  input  logic               resetb,
  iodiv_strobe_gen_if.slave  cfg,
  input  logic               sync,
  output logic [NUM_CH-1:0]  div_clk,
  output logic [NUM_CH-1:0]  strobe,
  output logic               frame_start,
  output logic [CNT_W-1:0]   active_divide
`ifdef IODIV_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);
  logic [CNT_W-1:0]        cnt_q, cnt_d, divide_q, divide_d, pend_divide_q, pend_divide_d;
  logic [NUM_CH*CNT_W-1:0] phase_q, phase_d, pend_phase_q, pend_phase_d;
  logic                    pend_valid_q, pend_valid_d, cfg_err_q, cfg_err_d;
  logic                    frame_start_q, frame_start_d;
  logic                    xfer, wrap, apply, legal;

  // Frame counter, config capture/validation and boundary apply.
  always_comb begin
    legal = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++)
      legal = legal & cfg_legal(LIM_W'(cfg.cfg_divide),
                                LIM_W'(cfg.cfg_phase[i*CNT_W +: CNT_W]), MAX_DIVIDE);
    xfer          = cfg.cfg_valid && !pend_valid_q;
    wrap          = (cnt_q >= (divide_q - CNT_W'(1)));
    apply         = pend_valid_q && (wrap || sync);
    cnt_d         = (wrap || sync) ? '0 : (cnt_q + CNT_W'(1));
    frame_start_d = (cnt_q == '0);
    divide_d      = divide_q;
    phase_d       = phase_q;
    pend_valid_d  = pend_valid_q;
    pend_divide_d = pend_divide_q;
    pend_phase_d  = pend_phase_q;
    cfg_err_d     = 1'b0;
    if (apply) begin
      divide_d     = pend_divide_q;
      phase_d      = pend_phase_q;
      pend_valid_d = 1'b0;
    end
    // xfer implies no pending config, so it never collides with apply.
    if (xfer) begin
      if (legal) begin
        pend_valid_d  = 1'b1;
        pend_divide_d = cfg.cfg_divide;
        pend_phase_d  = cfg.cfg_phase;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q         <= '0;
      divide_q      <= CNT_W'(RESET_DIVIDE);
      phase_q       <= '0;
      pend_valid_q  <= 1'b0;
      pend_divide_q <= '0;
      pend_phase_q  <= '0;
      cfg_err_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      divide_q      <= divide_d;
      phase_q       <= phase_d;
      pend_valid_q  <= pend_valid_d;
      pend_divide_q <= pend_divide_d;
      pend_phase_q  <= pend_phase_d;
      cfg_err_q     <= cfg_err_d;
      frame_start_q <= frame_start_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    iodiv_phase_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .resetb  (resetb),
      .cnt     (cnt_q),
      .divide  (divide_q),
      .phase   (phase_q[g*CNT_W +: CNT_W]),
      .div_clk (div_clk[g]),
      .strobe  (strobe[g])
    );
  end

  assign cfg.cfg_ready = !pend_valid_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign frame_start   = frame_start_q;
  assign active_divide = divide_q;

`ifdef IODIV_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Counts frame_start pulses in step with the registered pulse; sync clears.
  always_comb begin
    frame_count_d = sync ? '0 : (frame_count_q + 16'(frame_start_d));
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) frame_count_q <= '0;
    else         frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_iodiv_strobe_gen.sv
// Self-checking bench for iodiv_strobe_gen (MAX_DIVIDE=8, NUM_CH=2, RESET_DIVIDE=4).
module tb_iodiv_strobe_gen;
  logic       clk = 1'b0;
  logic       resetb;
  logic       sync;
  logic [1:0] div_clk, strobe;
  logic       frame_start;
  logic [3:0] active_divide;
`ifdef IODIV_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  iodiv_strobe_gen_if #(.NUM_CH(2), .CNT_W(4)) cfg_if ();

  iodiv_strobe_gen #(.MAX_DIVIDE(8), .NUM_CH(2), .RESET_DIVIDE(4)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .cfg           (cfg_if),
    .sync          (sync),
    .div_clk       (div_clk),
    .strobe        (strobe),
    .frame_start   (frame_start),
    .active_divide (active_divide)
`ifdef IODIV_FRAME_CNT_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position, active and pending config, expected outputs.
  int   m_cnt, m_div, m_ph[2], m_pend, m_pdiv, m_pph[2], m_fc;
  logic [1:0] e_dclk, e_strb;
  logic       e_fs, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_div = 4; m_ph[0] = 0; m_ph[1] = 0;
    m_pend = 0; m_pdiv = 0; m_pph[0] = 0; m_pph[1] = 0; m_fc = 0;
    e_dclk = '0; e_strb = '0; e_fs = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int d, input int p0, input int p1, input bit s);
    int  lc;
    bit  boundary, xfer;
    e_fs = (m_cnt == 0);
    for (int i = 0; i < 2; i++) begin
      lc        = (m_cnt + m_ph[i]) % m_div;
      e_strb[i] = (lc == m_div - 1);
      e_dclk[i] = (lc < (m_div + 1) / 2);
    end
    if (s) m_fc = 0;
    else if (e_fs) m_fc = (m_fc + 1) % 65536;
    boundary = s || (m_cnt == m_div - 1);
    xfer     = v && (m_pend == 0);
    e_err    = 1'b0;
    if (m_pend != 0 && boundary) begin
      m_div = m_pdiv; m_ph[0] = m_pph[0]; m_ph[1] = m_pph[1]; m_pend = 0;
    end
    if (xfer) begin
      if (d >= 1 && d <= 8 && p0 < d && p1 < d) begin
        m_pend = 1; m_pdiv = d; m_pph[0] = p0; m_pph[1] = p1;
      end else begin
        e_err = 1'b1;
      end
    end
    m_cnt = boundary ? 0 : m_cnt + 1;
  endtask

  task automatic check_all();
    chk("div_clk", 32'(div_clk), 32'(e_dclk));
    chk("strobe", 32'(strobe), 32'(e_strb));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("cfg_err", 32'(cfg_if.cfg_err), 32'(e_err));
    chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_pend == 0));
    chk("active_divide", 32'(active_divide), 32'(m_div));
`ifdef IODIV_FRAME_CNT_EN
    chk("frame_count", 32'(frame_count), 32'(m_fc));
`endif
  endtask

  // Drive inputs away from the edge, update the model at the edge, check at negedge.
  task automatic tick(input bit v, input int d, input int p0, input int p1, input bit s);
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_divide = 4'(d);
    cfg_if.cfg_phase  = {4'(p1), 4'(p0)};
    sync              = s;
    @(posedge clk);
    model_edge(v, d, p0, p1, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_div_clk"}, 32'(div_clk), 32'h0);
    chk({tag, "_strobe"}, 32'(strobe), 32'h0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    chk({tag, "_cfg_err"}, 32'(cfg_if.cfg_err), 32'h0);
    chk({tag, "_cfg_ready"}, 32'(cfg_if.cfg_ready), 32'h1);
    chk({tag, "_active_divide"}, 32'(active_divide), 32'h4);
  endtask

  initial begin
    logic [3:0] pat_clk, pat_stb;
    int d, p0, p1;

    resetb = 1'b1; sync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_divide = '0; cfg_if.cfg_phase = '0;
    #1 resetb = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    model_reset();
    resetb = 1'b1;

    // Default divide 4: div_clk[0] 1,1,0,0 and strobe[0] at the last count.
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, 0, 0);
      pat_clk[k] = div_clk[0];
      pat_stb[k] = strobe[0];
    end
    chk("div4_clk_pattern", 32'(pat_clk), 32'h3);
    chk("div4_strobe_pattern", 32'(pat_stb), 32'h8);
    repeat (6) tick(0, 0, 0, 0, 0);

    // Mid-frame request divide=5, ch1 phase 2; applied at the next wrap.
    tick(0, 0, 0, 0, 0);
    tick(1, 5, 0, 2, 0);
    for (int k = 0; k < 20 && m_pend != 0; k++) tick(0, 0, 0, 0, 0);
    chk("apply_div5", 32'(active_divide), 32'h5);
    repeat (12) tick(0, 0, 0, 0, 0);

    // Illegal requests: divide above maximum, phase not below divide.
    tick(1, 9, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 3, 0, 3, 0);
    tick(0, 0, 0, 0, 0);
    chk("rejected_keeps_div5", 32'(active_divide), 32'h5);

    // Divide by one: everything high every cycle.
    tick(1, 1, 0, 0, 0);
    for (int k = 0; k < 20 && m_pend != 0; k++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0, 0);
      chk("div1_clk", 32'(div_clk), 32'h3);
      chk("div1_strobe", 32'(strobe), 32'h3);
    end

    // Sync at cnt==2 with divide=6 pending.
    tick(1, 8, 0, 0, 0);
    for (int k = 0; k < 20 && m_pend != 0; k++) tick(0, 0, 0, 0, 0);
    for (int k = 0; k < 20 && m_cnt != 1; k++) tick(0, 0, 0, 0, 0);
    tick(1, 6, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("sync_apply_div6", 32'(active_divide), 32'h6);
`ifdef IODIV_FRAME_CNT_EN
    chk("sync_clears_frame_count", 32'(frame_count), 32'h0);
`endif
    repeat (8) tick(0, 0, 0, 0, 0);

    // Sync held high, then coincident with a natural wrap.
    repeat (4) tick(0, 0, 0, 0, 1);
    for (int k = 0; k < 20 && m_cnt != 5; k++) tick(0, 0, 0, 0, 0);
    tick(1, 3, 1, 2, 0);
    for (int k = 0; k < 20 && m_cnt != m_div - 1; k++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    repeat (6) tick(0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      d  = int'($urandom_range(0, 10));
      p0 = int'($urandom_range(0, d));
      p1 = int'($urandom_range(0, d));
      tick(($urandom % 3) == 0, d, p0, p1, ($urandom % 16) == 0);
    end

    // Asynchronous reset mid-frame with a config pending.
    for (int k = 0; k < 20 && m_pend != 0; k++) tick(0, 0, 0, 0, 0);
    tick(1, 7, 1, 2, 0);
    #2 resetb = 1'b0;
    #1 check_reset_values("midrun_reset");
    model_reset();
    @(negedge clk);
    resetb = 1'b1;
    repeat (12) tick(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
